// File: rtl/uart_tx_if.sv
// Write-side bundle of the UART transmitter: byte, mode and valid/ready handshake.
interface uart_tx_if;
    logic [7:0] uart_wr_data;
    logic       uart_wr_valid;
    logic       uart_wr_ready;
    logic [1:0] uart_mode;

    // Producer side (the block feeding bytes in).
    modport master (
        output uart_wr_data,
        output uart_wr_valid,
        output uart_mode,
        input  uart_wr_ready
    );

    // Consumer side (the transmit core).
    modport slave (
        input  uart_wr_data,
        input  uart_wr_valid,
        input  uart_mode,
        output uart_wr_ready
    );
endinterface

// File: rtl/uart_tx_core.sv
// Transmit half of the board UART: serialises accepted bytes as
// start + 8 data (LSB first) + optional parity + 1 or 2 stop bits.
// The line flop lags the state register by one clock, so the start bit
// appears one edge after accept while ready/busy track the next state.
module uart_tx_core #(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  tx_if,
    output logic      uart_txd,
    output logic      tx_busy
);

    localparam int unsigned BIT_CYCLES = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int unsigned CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

    localparam logic [1:0] MODE_8N1 = 2'b00;
    localparam logic [1:0] MODE_8E1 = 2'b01;
    localparam logic [1:0] MODE_8O1 = 2'b10;
    localparam logic [1:0] MODE_8N2 = 2'b11;

    generate
        if (BIT_CYCLES < 2) begin : g_bad_rate
            $error("uart_tx_core: BIT_CYCLES must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;     // unshifted copy, used for parity
    logic [1:0]       mode_q, mode_d;
    logic             stop2_q, stop2_d;   // first of two stop bits already sent
    logic             txd_q, txd_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

    logic bit_end;
    logic accept;
    logic has_parity;

    assign bit_end    = (cnt_q == CNT_LAST);
    assign accept     = tx_if.uart_wr_valid && ready_q;
    assign has_parity = (mode_q == MODE_8E1) || (mode_q == MODE_8O1);

    // Next-state, datapath and registered-output values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        mode_d    = mode_q;
        stop2_d   = stop2_q;
        txd_d     = 1'b1;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                txd_d = 1'b1;
                if (accept) begin
                    shift_d   = tx_if.uart_wr_data;
                    data_d    = tx_if.uart_wr_data;
                    mode_d    = tx_if.uart_mode;
                    bit_idx_d = 3'd0;
                    stop2_d   = 1'b0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                txd_d = 1'b0;
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                txd_d = shift_q[0];
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = has_parity ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                // Even parity is the plain XOR; odd parity inverts it.
                txd_d = (^data_q) ^ (mode_q == MODE_8O1);
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                txd_d = 1'b1;
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    if ((mode_q == MODE_8N2) && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Registered from the next state so they change on the accept and
        // frame-end edges themselves.
        ready_d = (state_d == StIdle);
        busy_d  = (state_d != StIdle);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            mode_q    <= MODE_8N1;
            stop2_q   <= 1'b0;
            txd_q     <= 1'b1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            mode_q    <= mode_d;
            stop2_q   <= stop2_d;
            txd_q     <= txd_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign uart_txd            = txd_q;
    assign tx_busy             = busy_q;
    assign tx_if.uart_wr_ready = ready_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: stimulus pushes expected frames into a scoreboard,
// a line monitor decodes uart_txd and checks every bit period against it.
module tb_uart_tx_core;

    localparam int BC = 868;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic txd;
    logic busy;

    uart_tx_if tx_if ();

    uart_tx_core #(
        .CLK_FREQ  (100000000),
        .BAUD_RATE (115200)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_if    (tx_if),
        .uart_txd (txd),
        .tx_busy  (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] data;
        logic [1:0] mode;
        logic       par;     // hand-computed parity bit (unused without parity)
        int         acc;     // cycle of the accept edge
        bit         b2b;     // expect exactly one idle clock before this frame
        bit         abort;   // frame is cut short by reset
    } exp_t;

    exp_t sb_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line monitor: decodes frames and compares with the scoreboard.
    initial begin : monitor
        exp_t       e;
        logic       bits [0:11];
        int         nb;
        int         start;
        int         prev_end;
        int         idx;
        logic [7:0] rx;
        bit         aborted;
        int         ok;
        prev_end = 0;
        forever begin
            @(negedge clk);
            if (rst && txd === 1'b0) begin
                start = cyc;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, none expected", cyc);
                    while (txd === 1'b0) @(negedge clk);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("start_latency_%02h", e.data), start - e.acc, 1);
                    if (e.b2b) chk($sformatf("idle_gap_%02h", e.data), start - prev_end, 1);
                    bits[0] = 1'b0;
                    for (int i = 0; i < 8; i++) bits[1 + i] = e.data[i];
                    idx = 9;
                    if (e.mode == 2'b01 || e.mode == 2'b10) begin
                        bits[9] = e.par;
                        idx = 10;
                    end
                    nb = idx + ((e.mode == 2'b11) ? 2 : 1);
                    for (int i = idx; i < nb; i++) bits[i] = 1'b1;
                    aborted = 1'b0;
                    rx = 8'h00;
                    for (int b = 0; b < nb && !aborted; b++) begin
                        ok = 1;
                        for (int j = 0; j < BC; j++) begin
                            if (b != 0 || j != 0) @(negedge clk);
                            if (!rst) begin
                                aborted = 1'b1;
                                break;
                            end
                            if (txd !== bits[b]) ok = 0;
                            if (j == BC / 2 && b >= 1 && b <= 8) rx[b - 1] = txd;
                        end
                        if (!aborted) chk($sformatf("frame_%02h_bit%0d_level", e.data, b), ok, 1);
                    end
                    if (e.abort) begin
                        chk($sformatf("frame_%02h_aborted", e.data), int'(aborted), 1);
                    end else begin
                        chk($sformatf("frame_%02h_no_abort", e.data), int'(aborted), 0);
                        if (!aborted) chk("rx_byte", rx, e.data);
                    end
                    prev_end = start + nb * BC;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [1:0] m, input logic par,
                        input bit b2b, input bit abort, input bit hold, output int acc);
        exp_t e;
        int   t;
        tx_if.uart_wr_data  = d;
        tx_if.uart_mode     = m;
        tx_if.uart_wr_valid = 1'b1;
        t = 0;
        while (!tx_if.uart_wr_ready && t < 20000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!tx_if.uart_wr_ready) begin
            chk($sformatf("ready_timeout_%02h", d), int'(tx_if.uart_wr_ready), 1);
            tx_if.uart_wr_valid = 1'b0;
            acc = cyc;
        end else begin
            @(posedge clk);
            #1;
            acc     = cyc;
            e.data  = d;
            e.mode  = m;
            e.par   = par;
            e.acc   = acc;
            e.b2b   = b2b;
            e.abort = abort;
            sb_q.push_back(e);
            if (!hold) tx_if.uart_wr_valid = 1'b0;
            chk($sformatf("ready_low_after_accept_%02h", d), int'(tx_if.uart_wr_ready), 0);
            chk($sformatf("busy_after_accept_%02h", d), int'(busy), 1);
        end
    endtask

    // Waits for ready and checks the accept-to-ready distance in bit periods.
    task automatic wait_done(input string name, input int acc, input int nbits);
        int t;
        t = 0;
        while (!tx_if.uart_wr_ready && t < nbits * BC + 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(name, cyc - acc, nbits * BC);
        chk({name, "_busy_low"}, int'(busy), 0);
    endtask

    initial begin : stim
        int a1;
        int a2;
        tx_if.uart_wr_valid = 1'b0;
        tx_if.uart_wr_data  = 8'h00;
        tx_if.uart_mode     = 2'b00;
        rst = 1'b0;

        repeat (10) begin
            @(posedge clk);
            #1;
            chk("reset_txd", int'(txd), 1);
            chk("reset_ready", int'(tx_if.uart_wr_ready), 0);
            chk("reset_busy", int'(busy), 0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_release", int'(tx_if.uart_wr_ready), 1);
        chk("txd_after_release", int'(txd), 1);

        // 8N1 0x55: 0,1,0,1,...,1 on the line.
        send(8'h55, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, a1);
        wait_done("frame_len_8n1_55", a1, 10);

        // 0xA5 has four ones: even parity 0, odd parity 1.
        send(8'hA5, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, a1);
        wait_done("frame_len_8e1_a5", a1, 11);
        send(8'hA5, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, a1);
        wait_done("frame_len_8o1_a5", a1, 11);

        // Back-to-back 8N2 with valid held; data swapped while the first is busy.
        send(8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, a1);
        send(8'hFF, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, a2);
        chk("b2b_accept_period", a2 - a1, 11 * BC + 1);
        wait_done("frame_len_8n2_ff", a2, 11);

        // Inputs changed mid-frame must not affect the frame.
        send(8'h81, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, a1);
        repeat (4 * BC) @(posedge clk);
        #1;
        tx_if.uart_wr_data = 8'h3C;
        tx_if.uart_mode    = 2'b01;
        chk("busy_mid_frame", int'(busy), 1);
        wait_done("frame_len_8n1_81", a1, 10);

        // Reset in the middle of data bit 3.
        send(8'hC3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, a1);
        repeat (1 + 4 * BC + BC / 2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_txd_high", int'(txd), 1);
        chk("abort_ready_low", int'(tx_if.uart_wr_ready), 0);
        chk("abort_busy_low", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_abort", int'(tx_if.uart_wr_ready), 1);

        send(8'h12, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, a1);
        wait_done("frame_len_8n1_12", a1, 10);

        repeat (2 * BC) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb_q.size(), 0);
        chk("final_txd_idle", int'(txd), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        repeat (95000) @(posedge clk);
        n_cmp++;
        n_fail++;
        $display("FAIL watchdog: bench still running at cycle %0d, limit 95000", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
